// File: rtl/spi_pkg.sv
// Shared defaults and idle pin levels for the SPI mode-0 slave.
package spi_pkg;

  localparam int unsigned DATAWIDTH_DEF   = 16;
  localparam int unsigned CMDWIDTH_DEF    = 32;
  localparam int unsigned SYNC_STAGES_DEF = 3;

  localparam logic SCK_IDLE  = 1'b0;
  localparam logic SSEL_IDLE = 1'b1;
  localparam logic MOSI_IDLE = 1'b0;

endpackage

// File: rtl/spi_slave_if.sv
// SPI pins plus the command/response side of the slave, grouped as one bundle.
interface spi_slave_if #(
  parameter int unsigned DATAWIDTH = spi_pkg::DATAWIDTH_DEF,
  parameter int unsigned CMDWIDTH  = spi_pkg::CMDWIDTH_DEF
);

  logic                 SCK;
  logic                 SSEL;
  logic                 MOSI;
  logic                 MISO;
  logic [CMDWIDTH-1:0]  DATA_OUT;
  logic                 DATA_READY;
  logic [DATAWIDTH-1:0] READ_OUT;

  modport master (
    output SCK, SSEL, MOSI, READ_OUT,
    input  MISO, DATA_OUT, DATA_READY
  );

  modport slave (
    input  SCK, SSEL, MOSI, READ_OUT,
    output MISO, DATA_OUT, DATA_READY
  );

endinterface

// File: rtl/spi_edge_sync.sv
// N-stage synchronizer; edges are detected on the two oldest stages.
module spi_edge_sync #(
  parameter int unsigned Stages  = 3,
  parameter logic        IdleVal = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_last,
  output logic o_prev,
  output logic o_rise,
  output logic o_fall
);

  logic [Stages-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {Stages{IdleVal}};
    end else begin
      r_sync <= {r_sync[Stages-2:0], i_async};
    end
  end

  assign o_last = r_sync[Stages-1];
  assign o_prev = r_sync[Stages-2];
  assign o_rise = ~r_sync[Stages-1] & r_sync[Stages-2];
  assign o_fall = r_sync[Stages-1] & ~r_sync[Stages-2];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, oversampled in the clk domain: receives command words on MOSI
// and repeats the READ_OUT response word on MISO.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned DATAWIDTH   = DATAWIDTH_DEF,
  parameter int unsigned CMDWIDTH    = CMDWIDTH_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  spi_slave_if.slave bus
);

  localparam int unsigned          RxCntW = $clog2(CMDWIDTH);
  localparam int unsigned          TxCntW = $clog2(DATAWIDTH);
  localparam logic [RxCntW-1:0]    RxLast = RxCntW'(CMDWIDTH - 1);
  localparam logic [TxCntW-1:0]    TxLast = TxCntW'(DATAWIDTH - 1);

  logic w_sck_rise, w_sck_fall;
  logic w_ssel_n, w_ssel_fall;
  logic w_mosi;
  logic w_unused_sck_last, w_unused_sck_prev, w_unused_ssel_last, w_unused_ssel_rise;
  logic w_unused_mosi_prev, w_unused_mosi_rise, w_unused_mosi_fall;

  logic [CMDWIDTH-1:0]  r_rx_shift;
  logic [RxCntW-1:0]    r_rx_cnt;
  logic                 r_done;
  logic [CMDWIDTH-1:0]  r_data_out;
  logic                 r_ready;
  logic [DATAWIDTH-1:0] r_tx_shift;
  logic [TxCntW-1:0]    r_tx_cnt;
  logic                 r_miso;

  spi_edge_sync #(.Stages(SYNC_STAGES), .IdleVal(SCK_IDLE)) u_sck_sync (
    .clk    (clk),
    .rst    (rst),
    .i_async(bus.SCK),
    .o_last (w_unused_sck_last),
    .o_prev (w_unused_sck_prev),
    .o_rise (w_sck_rise),
    .o_fall (w_sck_fall)
  );

  spi_edge_sync #(.Stages(SYNC_STAGES), .IdleVal(SSEL_IDLE)) u_ssel_sync (
    .clk    (clk),
    .rst    (rst),
    .i_async(bus.SSEL),
    .o_last (w_unused_ssel_last),
    .o_prev (w_ssel_n),
    .o_rise (w_unused_ssel_rise),
    .o_fall (w_ssel_fall)
  );

  // One stage shorter, so the sampled bit lines up with the detected SCK rise.
  spi_edge_sync #(.Stages(SYNC_STAGES - 1), .IdleVal(MOSI_IDLE)) u_mosi_sync (
    .clk    (clk),
    .rst    (rst),
    .i_async(bus.MOSI),
    .o_last (w_mosi),
    .o_prev (w_unused_mosi_prev),
    .o_rise (w_unused_mosi_rise),
    .o_fall (w_unused_mosi_fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_shift <= '0;
      r_rx_cnt   <= '0;
      r_done     <= 1'b0;
      r_data_out <= '0;
      r_ready    <= 1'b0;
      r_tx_shift <= '0;
      r_tx_cnt   <= '0;
      r_miso     <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      if (r_done && !w_ssel_n) begin
        r_data_out <= r_rx_shift;
        r_ready    <= 1'b1;
      end

      if (w_ssel_n) begin
        r_rx_cnt <= '0;
        r_tx_cnt <= '0;
        r_miso   <= 1'b0;
      end else if (w_ssel_fall) begin
        r_rx_cnt   <= '0;
        r_tx_cnt   <= '0;
        r_tx_shift <= bus.READ_OUT;
        r_miso     <= bus.READ_OUT[DATAWIDTH-1];
      end else begin
        if (w_sck_rise) begin
          r_rx_shift <= {r_rx_shift[CMDWIDTH-2:0], w_mosi};
          if (r_rx_cnt == RxLast) begin
            r_rx_cnt <= '0;
            r_done   <= 1'b1;
          end else begin
            r_rx_cnt <= r_rx_cnt + RxCntW'(1);
          end
        end
        // Reload on the falling edge after the last response bit was sampled.
        if (w_sck_fall) begin
          if (r_tx_cnt == TxLast) begin
            r_tx_cnt   <= '0;
            r_tx_shift <= bus.READ_OUT;
            r_miso     <= bus.READ_OUT[DATAWIDTH-1];
          end else begin
            r_tx_cnt   <= r_tx_cnt + TxCntW'(1);
            r_tx_shift <= {r_tx_shift[DATAWIDTH-2:0], 1'b0};
            r_miso     <= r_tx_shift[DATAWIDTH-2];
          end
        end
      end
    end
  end

  assign bus.DATA_OUT   = r_data_out;
  assign bus.DATA_READY = r_ready;
  assign bus.MISO       = r_miso;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: bit-level SPI master plus a word scoreboard checked every clk.
module tb_spi_slave;

  localparam int unsigned DW   = 16;
  localparam int unsigned CW   = 32;
  localparam int          HALF = 200;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_slave_if #(.DATAWIDTH(DW), .CMDWIDTH(CW)) bus ();

  spi_slave #(.DATAWIDTH(DW), .CMDWIDTH(CW), .SYNC_STAGES(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          n_cmp    = 0;
  int          n_err    = 0;
  int          n_pulse  = 0;
  int          cyc      = 0;
  int          idle_cnt = 0;
  logic [31:0] model_dout = 32'h0;
  logic [31:0] exp_word_q[$];
  int          exp_cyc_q[$];
  logic [63:0] got;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Every clk: pulses must match completed words 4 clk after their last SCK rise,
  // DATA_OUT must otherwise hold, MISO must be 0 once SSEL has been high a while.
  initial begin
    logic [31:0] w;
    int          c;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.SSEL === 1'b1) idle_cnt++;
      else idle_cnt = 0;
      if (bus.DATA_READY === 1'b1) begin
        n_pulse++;
        if (exp_word_q.size() == 0) begin
          check("unexpected_pulse", bus.DATA_READY, 0);
        end else begin
          w = exp_word_q.pop_front();
          c = exp_cyc_q.pop_front();
          check("dout_on_pulse", bus.DATA_OUT, w);
          check("ready_latency", cyc - c, 4);
          model_dout = w;
        end
      end else begin
        check("dout_hold", bus.DATA_OUT, model_dout);
      end
      if (idle_cnt >= 4) check("miso_idle", bus.MISO, 0);
    end
  end

  // bits is left-aligned: frame bit i is bits[63-i].
  task automatic run_frame(input logic [63:0] bits, input int nbits, input logic [DW-1:0] rd,
                           input bit sel, input bit keep_low, output logic [63:0] rx);
    rx = '0;
    bus.READ_OUT = rd;
    @(negedge clk);
    bus.SSEL = sel ? 1'b0 : 1'b1;
    for (int i = 0; i < nbits; i++) begin
      bus.MOSI = bits[63-i];
      #HALF;
      bus.SCK = 1'b1;
      rx[63-i] = bus.MISO;
      if (sel) check("miso_bit", bus.MISO, rd[DW-1-(i%DW)]);
      else check("miso_unsel", bus.MISO, 0);
      if (sel && (i % CW) == CW - 1) begin
        exp_word_q.push_back(bits[63-(i-31) -: 32]);
        exp_cyc_q.push_back(cyc);
      end
      #HALF;
      bus.SCK = 1'b0;
    end
    if (!keep_low) begin
      #HALF;
      bus.SSEL = 1'b1;
    end
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 60 && exp_word_q.size() != 0; k++) @(posedge clk);
    check(name, exp_word_q.size(), 0);
    repeat (10) @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst          = 1'b1;
    bus.SCK      = 1'b0;
    bus.SSEL     = 1'b1;
    bus.MOSI     = 1'b0;
    bus.READ_OUT = '0;
    repeat (5) @(negedge clk);
    check("rst_dout", bus.DATA_OUT, 0);
    check("rst_ready", bus.DATA_READY, 0);
    check("rst_miso", bus.MISO, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Write
    n_pulse = 0;
    run_frame({32'h8C8C8C8A, 32'h0}, 32, 16'h0000, 1'b1, 1'b0, got);
    drain("write_drain");
    check("write_dout", bus.DATA_OUT, 32'h8C8C8C8A);
    check("write_pulses", n_pulse, 1);

    // Read
    n_pulse = 0;
    run_frame(64'h0, 16, 16'hA3A3, 1'b1, 1'b0, got);
    drain("read_drain");
    check("read_word", got[63:48], 16'hA3A3);
    check("read_pulses", n_pulse, 0);
    check("read_dout", bus.DATA_OUT, 32'h8C8C8C8A);

    // Aborted write then full write
    n_pulse = 0;
    run_frame({32'h12345678, 32'h0}, 20, 16'h0F0F, 1'b1, 1'b0, got);
    drain("abort_drain");
    check("abort_pulses", n_pulse, 0);
    check("abort_dout", bus.DATA_OUT, 32'h8C8C8C8A);
    run_frame({32'hDEADBEEF, 32'h0}, 32, 16'h0F0F, 1'b1, 1'b0, got);
    drain("after_abort_drain");
    check("after_abort_dout", bus.DATA_OUT, 32'hDEADBEEF);
    check("after_abort_pulses", n_pulse, 1);

    // Back-to-back words, response repeats every 16 bits
    n_pulse = 0;
    run_frame({32'h11111111, 32'h22222222}, 64, 16'h5A3C, 1'b1, 1'b0, got);
    drain("b2b_drain");
    check("b2b_pulses", n_pulse, 2);
    check("b2b_dout", bus.DATA_OUT, 32'h22222222);
    check("b2b_miso", got, 64'h5A3C5A3C5A3C5A3C);

    // Reset mid-frame
    run_frame({32'hFFFFFFFF, 32'h0}, 10, 16'hFFFF, 1'b1, 1'b1, got);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_dout", bus.DATA_OUT, 0);
    check("midrst_miso", bus.MISO, 0);
    check("midrst_ready", bus.DATA_READY, 0);
    model_dout = 32'h0;
    exp_word_q.delete();
    exp_cyc_q.delete();
    bus.SSEL = 1'b1;
    bus.SCK  = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    n_pulse = 0;
    run_frame({32'hCAFEF00D, 32'h0}, 32, 16'h1234, 1'b1, 1'b0, got);
    drain("post_rst_drain");
    check("post_rst_dout", bus.DATA_OUT, 32'hCAFEF00D);
    check("post_rst_pulses", n_pulse, 1);

    // Idle: SCK toggles with SSEL high
    n_pulse = 0;
    run_frame({32'hFFFFFFFF, 32'hFFFFFFFF}, 32, 16'hFFFF, 1'b0, 1'b0, got);
    drain("idle_drain");
    check("idle_pulses", n_pulse, 0);
    check("idle_dout", bus.DATA_OUT, 32'hCAFEF00D);
    check("idle_miso", bus.MISO, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
